spi_bitrev_ctrl: RTL and testbench

SPI_BITREV_CTRL -- requirements
Module: spi_bitrev_ctrl

---
 rtl/spi_bitrev_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spi_bitrev_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bitrev_ctrl.sv
// spi_bitrev_ctrl: SPI master that sends one request byte to a bit-reverse
// slave, then clocks back its 8-bit reply and presents it as a response.
// Ports: clock, reset_n (async, active-low);
//   req_valid/req_ready/req_data : request handshake and byte to send;
//   rsp_valid/rsp_ready/rsp_data : response handshake and returned byte;
//   rsp_err : reply is not the bit-reversed request (option only, else 0);
//   sck/ss/mosi/miso : SPI pins (mode 0, ss active-low).
// Option: define BITREV_CTRL_CHECK_EN to build the reply comparator.
module spi_bitrev_ctrl #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       sck,
    output logic       ss,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [3:0] per_q, per_d;
    logic       half_q, half_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       sck_q, sck_d;
    logic       ss_q, ss_d;
    logic       mosi_q, mosi_d;

    logic       tick;
    logic [7:0] div_nxt;
    logic [2:0] nidx;

    // tick marks the last system clock of a CLK_DIV-long slot
    assign tick    = (div_q == DIV_LAST);
    assign div_nxt = tick ? 8'd0 : div_q + 8'd1;
    // bit presented after the falling edge of period p is tx_q[6-p]
    assign nidx    = 3'd6 - per_q[2:0];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        per_d   = per_q;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            S_IDLE: begin
                div_d = 8'd0;
                if (req_valid) begin
                    tx_d    = req_data;
                    mosi_d  = req_data[7];
                    ss_d    = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                div_d = div_nxt;
                if (tick) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                    per_d   = 4'd0;
                    half_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                div_d = div_nxt;
                if (tick) begin
                    if (!half_q) begin
                        // falling edge: advance mosi, sample reply
                        sck_d  = 1'b0;
                        half_d = 1'b1;
                        mosi_d = (per_q < 4'd7) ? tx_q[nidx] : 1'b0;
                        if (per_q[3]) begin
                            rx_d = {rx_q[6:0], miso};
                        end
                    end else if (per_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        per_d  = per_q + 4'd1;
                        half_d = 1'b0;
                        sck_d  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                div_d = div_nxt;
                if (tick) begin
                    state_d = S_RESP;
                    ss_d    = 1'b1;
                end
            end
            S_RESP: begin
                div_d = 8'd0;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = 8'd0;
                sck_d   = 1'b0;
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            per_q   <= 4'd0;
            half_q  <= 1'b0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            per_q   <= per_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rx_q;
    assign sck       = sck_q;
    assign ss        = ss_q;
    assign mosi      = mosi_q;

`ifdef BITREV_CTRL_CHECK_EN
    logic [7:0] tx_rev;

    always_comb begin
        tx_rev = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tx_rev[i] = tx_q[7-i];
        end
    end

    // rx_q and tx_q are frozen in RESP, so the flag is stable too
    assign rsp_err = (state_q == S_RESP) && (rx_q != tx_rev);
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bitrev_ctrl.sv
// tb_spi_bitrev_ctrl: scoreboard bench for spi_bitrev_ctrl with a
// behavioural bit-reverse slave; second instance runs at CLK_DIV=1.
module tb_spi_bitrev_ctrl;

    localparam int CD = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [7:0] req_data, rsp_data;
    logic       sck, ss, mosi, miso;

    logic       req_valid1, req_ready1, rsp_valid1, rsp_err1;
    logic       rsp_ready1;
    logic [7:0] req_data1, rsp_data1;
    logic       sck1, ss1, mosi1, miso1;

    always #5 clock = ~clock;

    spi_bitrev_ctrl #(.CLK_DIV(CD)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_bitrev_ctrl #(.CLK_DIV(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_data(req_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_err(rsp_err1), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chkb(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // reference: bit i of the input becomes bit 7-i of the result
    function automatic logic [7:0] rev8(input logic [7:0] b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((int'(b) >> i) & 1);
        return 8'(r);
    endfunction

    function automatic logic exp_err(input logic [7:0] tx, input logic [7:0] rx);
`ifdef BITREV_CTRL_CHECK_EN
        return rx != rev8(tx);
`else
        return (tx == rx) && 1'b0;
`endif
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         acc;
    } exp_t;

    exp_t sb[$];

    // slave models: sample mosi on sck rise (8 bits), then return reversed
    logic force1 = 1'b0;
    logic miso_m = 1'b0;
    logic miso_m1 = 1'b0;
    int   s_cnt = 0, s_cnt1 = 0;
    logic [7:0] s_rx = 8'd0, s_rx1 = 8'd0;

    assign miso  = force1 ? 1'b1 : miso_m;
    assign miso1 = miso_m1;

    initial forever begin
        @(posedge sck or posedge ss);
        if (ss) begin
            s_cnt = 0;
            s_rx  = 8'd0;
        end else begin
            if (s_cnt < 8) s_rx = {s_rx[6:0], mosi};
            else begin
                chkb("mosi_zero_tail", mosi, 1'b0);
                miso_m = s_rx[s_cnt-8];
            end
            s_cnt++;
        end
    end

    initial forever begin
        @(posedge sck1 or posedge ss1);
        if (ss1) begin
            s_cnt1 = 0;
            s_rx1  = 8'd0;
        end else begin
            if (s_cnt1 < 8) s_rx1 = {s_rx1[6:0], mosi1};
            else miso_m1 = s_rx1[s_cnt1-8];
            s_cnt1++;
        end
    end

    // rsp_ready driver: 0 = hold low, 1 = hold high, 2 = random
    int rr_mode = 1;
    initial forever begin
        @(negedge clock);
        rsp_ready = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end

    // monitor
    logic abort_f = 1'b0;
    logic m_pv = 0, m_pr = 0, m_pss = 1, m_psck = 0, m_pmosi = 0, m_pe = 0;
    logic [7:0] m_pd = 8'd0;
    int   ss_low = 0;
    exp_t m_e;

    initial forever begin
        @(negedge clock);
        #1;
        if (!reset_n || abort_f) begin
            ss_low = 0;
        end else begin
            if (ss) begin
                chkb("idle_sck", sck, 1'b0);
                chkb("idle_mosi", mosi, 1'b0);
            end
            if (ss != m_pss) chkb("ss_edge_sck", m_psck | sck, 1'b0);
            if (sck && m_psck) chkb("mosi_stable_hi", mosi, m_pmosi);
            if (!ss) ss_low++;
            else if (!m_pss) begin
                chki("ss_low_len", ss_low, 34 * CD);
                ss_low = 0;
            end
            if (rsp_valid && !m_pv && sb.size() > 0)
                chki("latency", cyc - sb[0].acc + 1, 1 + 34 * CD);
            if (m_pv && !m_pr) begin
                chkb("rsp_hold", rsp_valid, 1'b1);
                chk8("rsp_data_stable", rsp_data, m_pd);
                chkb("rsp_err_stable", rsp_err, m_pe);
            end
            if (rsp_valid && rsp_ready) begin
                chki("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    chk8("rsp_data", rsp_data, m_e.d);
                    chkb("rsp_err", rsp_err, m_e.e);
                end
            end
        end
        m_pv = rsp_valid; m_pr = rsp_ready; m_pss = ss; m_psck = sck;
        m_pmosi = mosi; m_pd = rsp_data; m_pe = rsp_err;
    end

    task automatic send(input logic [7:0] d);
        int n;
        logic [7:0] ed;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_data  = d;
        while (!req_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        chkb("accept_in_time", req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0;
        ed = force1 ? 8'hFF : rev8(d);
        sb.push_back('{d: ed, e: exp_err(d, ed), acc: cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chki("drain", sb.size(), 0);
    endtask

    initial begin
        int n, k, pulses, bad;
        logic p, got, e1;
        logic [7:0] d1;
        reset_n = 1'b0; req_valid = 1'b0; req_data = 8'd0;
        req_valid1 = 1'b0; req_data1 = 8'd0; rsp_ready1 = 1'b1;
        repeat (3) @(negedge clock);
        chkb("rst_ss", ss, 1'b1);
        chkb("rst_sck", sck, 1'b0);
        chkb("rst_mosi", mosi, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chk8("rst_rsp_data", rsp_data, 8'd0);
        chkb("rst_rsp_err", rsp_err, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        chkb("rst_req_ready", req_ready, 1'b1);

        send(8'hA5);
        drain();

        rr_mode = 2;
        repeat (24) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send(8'($urandom()));
        end
        drain();

        // back-pressure with a second request pending
        rr_mode = 0;
        send(8'h5A);
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        chkb("bp_valid_seen", rsp_valid, 1'b1);
        req_valid = 1'b1;
        req_data  = 8'hFF;
        repeat (20) begin
            @(negedge clock);
            chkb("bp_req_ready", req_ready, 1'b0);
        end
        rr_mode = 1;
        send(8'hFF);
        drain();

        // reset during period 5 of SHIFT
        send(8'hC3);
        repeat (CD + 10 * CD + 1) @(negedge clock);
        chkb("abort_in_shift", ss, 1'b0);
        abort_f = 1'b1;
        void'(sb.pop_back());
        #2 reset_n = 1'b0;
        #1;
        chkb("abort_ss", ss, 1'b1);
        chkb("abort_sck", sck, 1'b0);
        chkb("abort_rsp_valid", rsp_valid, 1'b0);
        chk8("abort_rsp_data", rsp_data, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        abort_f = 1'b0;
        send(8'h3C);
        drain();

        // miso stuck high
        force1 = 1'b1;
        send(8'h0F);
        send(8'hFF);
        drain();
        force1 = 1'b0;

        // CLK_DIV=1 instance: waveform shape and reply
        @(negedge clock);
        chkb("d1_ready", req_ready1, 1'b1);
        req_valid1 = 1'b1;
        req_data1  = 8'h01;
        @(negedge clock);
        req_valid1 = 1'b0;
        k = 0; pulses = 0; bad = 0; p = 1'b0; got = 1'b0;
        d1 = 8'd0; e1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid1 && !got) begin
                got = 1'b1;
                d1  = rsp_data1;
                e1  = rsp_err1;
            end
            if (!ss1) begin
                if (sck1 !== ((k >= 1 && k <= 32) ? k[0] : 1'b0)) bad++;
                if (sck1 && !p) pulses++;
                k++;
            end
            p = sck1;
            @(negedge clock);
        end
        chki("d1_sck_shape", bad, 0);
        chki("d1_pulses", pulses, 16);
        chki("d1_ss_len", k, 34);
        chkb("d1_valid_seen", got, 1'b1);
        chk8("d1_data", d1, rev8(8'h01));
        chkb("d1_err", e1, exp_err(8'h01, rev8(8'h01)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL global_timeout: got time %0t expected finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
